ternary_symbol_detector: RTL and testbench
==========================================

TERNARY_SYMBOL_DETECTOR -- requirements
Module: ternary_symbol_detector

Interface
REQ-001 Parameter WIDTH, default 16: signed sample width of in_data.
REQ-002 Parameter SPS_LOG2, default 3: log2 of samples per symbol; SPS = 2^SPS_LOG2; legal range 1..8.
REQ-003 Derived width ACCW = WIDTH+SPS_LOG2+1 for the accumulator, metric and thr.
REQ-004 clk  in  1  clock; all logic rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 en  in  1  block enable; low forces IDLE.
REQ-007 sync  in  1  symbol-alignment strobe; qualified by in_valid.
REQ-008 in_valid  in  1  in_data valid this cycle.
REQ-009 in_data  in  WIDTH signed  received sample stream; polarity-modulated +2x/-2x/0 per symbol.
REQ-010 thr  in  ACCW unsigned  decision threshold; sampled on the decision edge.
REQ-011 out_valid  out  1  one-cycle pulse; decision outputs updated.
REQ-012 sel_1  out  1  positive-symbol decision.
REQ-013 sel_2  out  1  negative-symbol decision.
REQ-014 metric  out  ACCW signed  integrated sum behind the last decision.
REQ-015 slip  out  1  one-cycle pulse; a partial symbol was discarded.

Function
REQ-016 Two states: IDLE (waiting for alignment) and INTEG (integrating a symbol).
REQ-017 IDLE->INTEG when en=1, in_valid=1 and sync=1 on the same cycle; that sample is sample 0 of the symbol.
REQ-018 In IDLE, samples without sync are ignored; acc=0 and cnt=0.
REQ-019 In INTEG, each in_valid cycle adds sign-extended in_data to acc and increments cnt (SPS_LOG2 bits).
REQ-020 Cycles with in_valid=0 hold acc and cnt; gaps of any length do not alter the result.
REQ-021 The accepted sample with cnt=SPS-1 is the last sample; on that edge the decision uses sum = acc + in_data.
REQ-022 Decision rule (signed compare, thr zero-extended):
- sum > thr: sel_1=1, sel_2=0.
- sum < -thr: sel_1=0, sel_2=1.
- Otherwise, including equality: sel_1=0, sel_2=0.
REQ-023 On the decision edge: metric <= sum, out_valid <= 1, acc <= 0, cnt <= 0; state stays INTEG (free-running symbol framing).
REQ-024 Latency: decision outputs are visible in the cycle after the last sample is presented.
REQ-025 sel_1, sel_2 and metric hold their values between decisions; out_valid is high for exactly one cycle per symbol.
REQ-026 sel_1 and sel_2 are never both 1.
REQ-027 An in_valid & sync cycle in INTEG with cnt != 0:
- discards the partial symbol; no out_valid;
- slip <= 1 for one cycle;
- restarts with that sample as sample 0 (acc <= in_data, cnt <= 1).
REQ-028 sync on the last-sample cycle (cnt=SPS-1): the symbol completes normally with out_valid; slip pulses; the next symbol starts at cnt=0.
REQ-029 sync at cnt=0 in INTEG re-aligns silently: no slip, sample counted normally.
REQ-030 en=0 in any state: IDLE next cycle; acc and cnt cleared; no out_valid or slip; decision outputs hold.
REQ-031 Accumulator never overflows: ACCW covers SPS*(-2^(WIDTH-1)); no saturation logic.

Reset
REQ-032 rst=1: state=IDLE, acc=0, cnt=0, out_valid=0, sel_1=0, sel_2=0, metric=0, slip=0 on the next edge.
REQ-033 rst takes priority over en, sync and in_valid.
REQ-034 rst mid-symbol discards the partial symbol; no decision until the next sync.

Verification (WIDTH=16, SPS_LOG2=3, thr=100)
REQ-035 Positive symbol: sync + 8 contiguous samples of +20 -> one cycle after the 8th sample: out_valid=1, sel_1=1, sel_2=0, metric=160.
REQ-036 Negative symbol and gaps: 8 samples of -20 with in_valid low 1-3 cycles between samples -> sel_2=1, sel_1=0, metric=-160, single out_valid.
REQ-037 Threshold boundary:
- seven of +12 then +16 (sum=100) -> sel_1=sel_2=0, metric=100;
- repeat with last sample +17 -> sel_1=1, metric=101.
REQ-038 Slip: sync, 5 samples of +20, sync + 8 samples of +20 -> slip pulses once, no out_valid for the partial symbol, then one out_valid with metric=160.
REQ-039 Extremes: 8 samples of -32768 -> metric=-262144, sel_2=1; 8 samples of +32767 -> metric=262136, sel_1=1.
REQ-040 Reset/enable mid-symbol: rst (or en=0) after 4 samples -> outputs 0 (rst) or held (en), no out_valid; samples without sync are ignored until the next sync.

Source files
------------

// File: rtl/ternary_symbol_detector.sv
// Integrate-and-dump detector for a ternary (+/-/0) polarity-modulated sample
// stream: one signed sum per SPS-sample symbol, compared against +/-thr.
module ternary_symbol_detector #(
  parameter int WIDTH    = 16,
  parameter int SPS_LOG2 = 3,
  localparam int ACCW    = WIDTH + SPS_LOG2 + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   sync,
  input  logic                   in_valid,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic        [ACCW-1:0]  thr,
  output logic                   out_valid,
  output logic                   sel_1,
  output logic                   sel_2,
  output logic signed [ACCW-1:0]  metric,
  output logic                   slip
);

  typedef enum logic {IDLE, INTEG} state_t;

  state_t                 state;
  logic signed [ACCW-1:0] acc;
  logic [SPS_LOG2-1:0]    cnt;
  logic signed [ACCW-1:0] samp;
  logic signed [ACCW-1:0] sum;
  logic signed [ACCW:0]   sum_x;
  logic signed [ACCW:0]   thr_x;
  logic                   last;

  assign samp  = {{(ACCW-WIDTH){in_data[WIDTH-1]}}, in_data};
  assign sum   = acc + samp;
  // One extra bit so an unsigned thr near 2^ACCW still compares correctly.
  assign sum_x = {sum[ACCW-1], sum};
  assign thr_x = {1'b0, thr};
  assign last  = &cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      sel_1     <= 1'b0;
      sel_2     <= 1'b0;
      metric    <= '0;
      slip      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      slip      <= 1'b0;
      if (!en) begin
        state <= IDLE;
        acc   <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            acc <= '0;
            cnt <= '0;
            if (in_valid && sync) begin
              state <= INTEG;
              acc   <= samp;
              cnt   <= SPS_LOG2'(1);
            end
          end
          INTEG: begin
            if (in_valid) begin
              if (last) begin
                // A sync on the final sample still completes the symbol.
                out_valid <= 1'b1;
                metric    <= sum;
                sel_1     <= (sum_x > thr_x);
                sel_2     <= (sum_x < -thr_x);
                slip      <= sync;
                acc       <= '0;
                cnt       <= '0;
              end else if (sync && cnt != '0) begin
                slip <= 1'b1;
                acc  <= samp;
                cnt  <= SPS_LOG2'(1);
              end else begin
                acc <= sum;
                cnt <= cnt + SPS_LOG2'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ternary_symbol_detector.sv
// Self-checking bench: table of whole symbols plus hand sequences for slip,
// reset and enable; decisions are checked against a scoreboard queue.
module tb_ternary_symbol_detector;
  localparam int W    = 16;
  localparam int L    = 3;
  localparam int SPS  = 8;
  localparam int ACCW = W + L + 1;

  logic                   clk = 1'b0;
  logic                   rst, en, sync, in_valid;
  logic signed [W-1:0]    in_data;
  logic        [ACCW-1:0] thr;
  logic                   out_valid, sel_1, sel_2, slip;
  logic signed [ACCW-1:0] metric;

  ternary_symbol_detector #(.WIDTH(W), .SPS_LOG2(L)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .in_valid(in_valid),
    .in_data(in_data), .thr(thr), .out_valid(out_valid), .sel_1(sel_1),
    .sel_2(sel_2), .metric(metric), .slip(slip)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                   s1;
    logic                   s2;
    logic signed [ACCW-1:0] m;
  } exp_t;

  typedef struct {
    logic signed [W-1:0]    a;
    logic signed [W-1:0]    last;
    bit                     gaps;
    logic                   s1;
    logic                   s2;
    logic signed [ACCW-1:0] m;
  } vec_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   slips  = 0;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (slip === 1'b1) slips++;
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid actual=1 required=0 at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sel_1", sel_1, e.s1);
        chk("sel_2", sel_2, e.s2);
        chk("metric", metric, e.m);
        chk("sel_exclusive", sel_1 & sel_2, 0);
      end
    end
  end

  task automatic step(input logic s, input logic v, input logic signed [W-1:0] d);
    sync = s; in_valid = v; in_data = d;
    @(posedge clk); #1;
    sync = 1'b0; in_valid = 1'b0; in_data = '0;
  endtask

  // Drive one full symbol: seven of a, then last; expectation pushed with last.
  task automatic sym(input logic signed [W-1:0] a, input logic signed [W-1:0] last,
                     input bit gaps, input bit with_sync, input bit expect_out,
                     input logic s1, input logic s2, input logic signed [ACCW-1:0] m);
    for (int i = 0; i < SPS; i++) begin
      if (i == SPS - 1) begin
        if (expect_out) q.push_back('{s1, s2, m});
        step(1'b0, 1'b1, last);
        if (expect_out) chk("latency_out_valid", out_valid, 1);
      end else begin
        step(with_sync && i == 0, 1'b1, a);
        if (gaps) repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 16'sd0);
      end
    end
  endtask

  vec_t vt[9];
  int   s0;

  initial begin
    vt[0] = '{16'sd20,     16'sd20,     1'b0, 1'b1, 1'b0, 20'sd160};
    vt[1] = '{-16'sd20,    -16'sd20,    1'b1, 1'b0, 1'b1, -20'sd160};
    vt[2] = '{16'sd12,     16'sd16,     1'b0, 1'b0, 1'b0, 20'sd100};
    vt[3] = '{16'sd12,     16'sd17,     1'b0, 1'b1, 1'b0, 20'sd101};
    vt[4] = '{-16'sd12,    -16'sd16,    1'b0, 1'b0, 1'b0, -20'sd100};
    vt[5] = '{-16'sd12,    -16'sd17,    1'b1, 1'b0, 1'b1, -20'sd101};
    vt[6] = '{-16'sd32768, -16'sd32768, 1'b0, 1'b0, 1'b1, -20'sd262144};
    vt[7] = '{16'sd32767,  16'sd32767,  1'b0, 1'b1, 1'b0, 20'sd262136};
    vt[8] = '{16'sd0,      16'sd0,      1'b0, 1'b0, 1'b0, 20'sd0};

    rst = 1'b1; en = 1'b1; sync = 1'b0; in_valid = 1'b0; in_data = '0; thr = 20'd100;
    step(1'b0, 1'b0, 16'sd0);
    step(1'b1, 1'b1, 16'sd20);   // reset wins over a sync sample
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sel_1", sel_1, 0);
    chk("rst_sel_2", sel_2, 0);
    chk("rst_metric", metric, 0);
    chk("rst_slip", slip, 0);
    rst = 1'b0;

    // Samples without sync in IDLE are ignored (monitor flags any decision).
    repeat (10) step(1'b0, 1'b1, 16'sd20);

    // Table: each symbol starts with sync at cnt=0, which must not slip.
    s0 = slips;
    foreach (vt[i])
      sym(vt[i].a, vt[i].last, vt[i].gaps, 1'b1, 1'b1, vt[i].s1, vt[i].s2, vt[i].m);
    repeat (2) step(1'b0, 1'b0, 16'sd0);
    chk("table_no_slip", slips - s0, 0);
    chk("hold_metric", metric, 0);

    // Slip: partial symbol of 5 discarded, then a full symbol.
    s0 = slips;
    for (int i = 0; i < 5; i++) step(i == 0, 1'b1, 16'sd20);
    sym(16'sd20, 16'sd20, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20'sd160);
    step(1'b0, 1'b0, 16'sd0);
    chk("slip_count", slips - s0, 1);

    // Sync on the last sample: completes normally, slips, next symbol framed at 0.
    s0 = slips;
    for (int i = 0; i < SPS - 1; i++) step(i == 0, 1'b1, -16'sd20);
    q.push_back('{1'b0, 1'b1, -20'sd160});
    step(1'b1, 1'b1, -16'sd20);
    chk("last_sync_out_valid", out_valid, 1);
    chk("last_sync_slip", slip, 1);
    sym(16'sd15, 16'sd15, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 20'sd120);
    chk("last_sync_slip_count", slips - s0, 1);

    // Reset mid-symbol: outputs clear, unsynced samples ignored afterwards.
    for (int i = 0; i < 4; i++) step(i == 0, 1'b1, 16'sd20);
    rst = 1'b1; step(1'b0, 1'b1, 16'sd20); rst = 1'b0;
    chk("midrst_metric", metric, 0);
    chk("midrst_sel_1", sel_1, 0);
    chk("midrst_out_valid", out_valid, 0);
    repeat (12) step(1'b0, 1'b1, 16'sd20);
    sym(-16'sd20, -16'sd20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, -20'sd160);

    // Enable drop mid-symbol: decision outputs hold.
    for (int i = 0; i < 4; i++) step(i == 0, 1'b1, 16'sd20);
    en = 1'b0; step(1'b0, 1'b1, 16'sd20); en = 1'b1;
    chk("en_hold_metric", metric, -160);
    chk("en_hold_sel_2", sel_2, 1);
    chk("en_out_valid", out_valid, 0);
    repeat (12) step(1'b0, 1'b1, 16'sd20);
    sym(16'sd20, 16'sd20, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 20'sd160);

    repeat (3) step(1'b0, 1'b0, 16'sd0);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
